// File: rtl/mem_byte_lsu_if.sv
// Request/response handshake and byte-wide scratch memory port of the LSU.
// The slave view is the sequencer; the master view is the core plus memory.
interface mem_byte_lsu_if #(
   parameter int ADDR_W = 4
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  rsp_ready, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output rsp_ready, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_byte_lsu.sv
// Byte/halfword/word load-store sequencer over a byte-wide scratch memory port.
// Define MEM_BYTE_LSU_MISALIGN_EN to execute misaligned requests instead of erroring.
module mem_byte_lsu #(
   parameter int ADDR_W = 4
) (
   input  logic          clk,
   input  logic          rst,
   mem_byte_lsu_if.slave bus
);
   typedef enum logic [2:0] {IDLE, WR, RD, CAP, RSP} state_t;

   state_t            state_reg, state_next;
   logic [1:0]        k_reg, k_next;
   logic [1:0]        last_reg, last_next;
   logic [ADDR_W-1:0] base_reg, base_next;
   logic              uns_reg, uns_next;
   logic [31:0]       wdata_reg, wdata_next;
   logic [31:0]       data_reg;
   logic              mem_we_reg, mem_we_next;
   logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
   logic [7:0]        mem_wdata_reg, mem_wdata_next;
   logic              rsp_valid_reg, rsp_valid_next;
   logic              rsp_err_reg, rsp_err_next;
   logic [31:0]       rsp_rdata_reg, rsp_rdata_next;

   logic              cap_en;
   logic [1:0]        cap_idx;
   logic [1:0]        req_last;
   logic              req_bad;
   logic [1:0]        k_inc;
   logic [31:0]       load_word;
   logic [31:0]       load_ext;

   function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
      logic [7:0] b;
      case (i)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      return b;
   endfunction

   // Index of the last byte of the request: 0, 1 or 3.
   always_comb begin
      case (bus.req_size)
         2'b00:   req_last = 2'd0;
         2'b01:   req_last = 2'd1;
         default: req_last = 2'd3;
      endcase
   end

`ifdef MEM_BYTE_LSU_MISALIGN_EN
   assign req_bad = (bus.req_size == 2'b11);
`else
   assign req_bad = (bus.req_size == 2'b11) || ((bus.req_addr[1:0] & req_last) != 2'b00);
`endif

   assign k_inc = k_reg + 2'd1;

   // The final byte arrives in CAP, so it is merged straight from the port.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         always_ff @(posedge clk) begin
            if (rst)
               data_reg[gi*8 +: 8] <= 8'h00;
            else if (cap_en && cap_idx == 2'(gi))
               data_reg[gi*8 +: 8] <= bus.mem_rdata;
         end
         assign load_word[gi*8 +: 8] = (last_reg == 2'(gi)) ? bus.mem_rdata : data_reg[gi*8 +: 8];
      end
   endgenerate

   // Upper lanes may hold stale bytes from earlier loads; extension overwrites them.
   always_comb begin
      case (last_reg)
         2'd0:    load_ext = {{24{~uns_reg & load_word[7]}}, load_word[7:0]};
         2'd1:    load_ext = {{16{~uns_reg & load_word[15]}}, load_word[15:0]};
         default: load_ext = load_word;
      endcase
   end

   always_comb begin
      state_next     = state_reg;
      k_next         = k_reg;
      last_next      = last_reg;
      base_next      = base_reg;
      uns_next       = uns_reg;
      wdata_next     = wdata_reg;
      mem_we_next    = 1'b0;
      mem_addr_next  = mem_addr_reg;
      mem_wdata_next = mem_wdata_reg;
      rsp_valid_next = rsp_valid_reg;
      rsp_err_next   = rsp_err_reg;
      rsp_rdata_next = rsp_rdata_reg;
      cap_en         = 1'b0;
      cap_idx        = 2'd0;

      case (state_reg)
         IDLE: begin
            if (bus.req_valid) begin
               base_next  = bus.req_addr;
               last_next  = req_last;
               uns_next   = bus.req_unsigned;
               wdata_next = bus.req_wdata;
               k_next     = 2'd0;
               if (req_bad) begin
                  state_next     = RSP;
                  rsp_valid_next = 1'b1;
                  rsp_err_next   = 1'b1;
                  rsp_rdata_next = 32'h0;
               end else if (bus.req_we) begin
                  state_next     = WR;
                  mem_we_next    = 1'b1;
                  mem_addr_next  = bus.req_addr;
                  mem_wdata_next = bus.req_wdata[7:0];
               end else begin
                  state_next    = RD;
                  mem_addr_next = bus.req_addr;
               end
            end
         end
         WR: begin
            if (k_reg == last_reg) begin
               state_next     = RSP;
               rsp_valid_next = 1'b1;
               rsp_err_next   = 1'b0;
               rsp_rdata_next = 32'h0;
            end else begin
               k_next         = k_inc;
               mem_we_next    = 1'b1;
               mem_addr_next  = base_reg + ADDR_W'(k_inc);
               mem_wdata_next = byte_of(wdata_reg, k_inc);
            end
         end
         RD: begin
            // mem_rdata answers the address issued one cycle earlier.
            cap_en  = (k_reg != 2'd0);
            cap_idx = k_reg - 2'd1;
            if (k_reg == last_reg) begin
               state_next = CAP;
            end else begin
               k_next        = k_inc;
               mem_addr_next = base_reg + ADDR_W'(k_inc);
            end
         end
         CAP: begin
            cap_en         = 1'b1;
            cap_idx        = last_reg;
            state_next     = RSP;
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b0;
            rsp_rdata_next = load_ext;
         end
         RSP: begin
            if (bus.rsp_ready) begin
               state_next     = IDLE;
               rsp_valid_next = 1'b0;
               rsp_err_next   = 1'b0;
               rsp_rdata_next = 32'h0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         k_reg         <= 2'd0;
         last_reg      <= 2'd0;
         base_reg      <= '0;
         uns_reg       <= 1'b0;
         wdata_reg     <= 32'h0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= 8'h00;
         rsp_valid_reg <= 1'b0;
         rsp_err_reg   <= 1'b0;
         rsp_rdata_reg <= 32'h0;
      end else begin
         state_reg     <= state_next;
         k_reg         <= k_next;
         last_reg      <= last_next;
         base_reg      <= base_next;
         uns_reg       <= uns_next;
         wdata_reg     <= wdata_next;
         mem_we_reg    <= mem_we_next;
         mem_addr_reg  <= mem_addr_next;
         mem_wdata_reg <= mem_wdata_next;
         rsp_valid_reg <= rsp_valid_next;
         rsp_err_reg   <= rsp_err_next;
         rsp_rdata_reg <= rsp_rdata_next;
      end
   end

   assign bus.req_ready = (state_reg == IDLE) && !rst;
   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_err   = rsp_err_reg;
   assign bus.rsp_rdata = rsp_rdata_reg;
   assign bus.mem_we    = mem_we_reg;
   assign bus.mem_addr  = mem_addr_reg;
   assign bus.mem_wdata = mem_wdata_reg;
endmodule

// File: tb/tb_mem_byte_lsu.sv
// Bench for mem_byte_lsu: directed and random requests against a byte-array
// reference model, with a 16-byte registered-read memory attached to the port.
module tb_mem_byte_lsu;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;
`ifdef MEM_BYTE_LSU_MISALIGN_EN
   localparam bit MIS = 1'b1;
`else
   localparam bit MIS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_byte_lsu_if #(.ADDR_W(ADDR_W)) bus();

   mem_byte_lsu #(.ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0]        mem [DEPTH] = '{default: 8'h00};
   logic [ADDR_W-1:0] raddr_q = '0;
   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      raddr_q <= bus.mem_addr;
   end
   assign bus.mem_rdata = mem[raddr_q];

   logic [7:0] ref_mem [DEPTH];
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mem_check(input string tag);
      int bad;
      bad = 0;
      for (int i = 0; i < DEPTH; i++)
         if (mem[i] !== ref_mem[i]) bad++;
      check({tag, "_mem"}, 32'(bad), 32'd0);
   endtask

   task automatic run(input logic we, input logic [1:0] size, input logic uns,
                      input logic [3:0] addr, input logic [31:0] wdata,
                      input int hold, input string tag);
      int n, exp_lat, lat, wcnt;
      bit err;
      logic [31:0] exp_data, snap_rdata;
      logic [3:0] addr_before;

      n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      err = (size == 2'd3) || (!MIS && (int'(addr) % n != 0));
      exp_data = 32'h0;
      if (!err) begin
         if (we) begin
            for (int i = 0; i < n; i++) ref_mem[4'(addr + 4'(i))] = wdata[8*i +: 8];
         end else begin
            for (int i = 0; i < n; i++) exp_data |= 32'(ref_mem[4'(addr + 4'(i))]) << (8*i);
            if (!uns && n < 4 && exp_data[8*n-1]) exp_data |= ~((32'd1 << (8*n)) - 32'd1);
         end
      end
      exp_lat = err ? 1 : (we ? n + 1 : n + 2);

      check({tag, "_ready_before"}, 32'(bus.req_ready), 32'd1);
      addr_before      = bus.mem_addr;
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      tick();
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'($urandom);
      bus.req_size     = 2'($urandom);
      bus.req_unsigned = 1'($urandom);
      bus.req_addr     = 4'($urandom);
      bus.req_wdata    = $urandom;

      lat  = 1;
      wcnt = 0;
      while (!bus.rsp_valid && lat < 20) begin
         wcnt += int'(bus.mem_we);
         tick();
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_writes"}, 32'(wcnt), (err || !we) ? 32'd0 : 32'(n));
      check({tag, "_rdata"}, bus.rsp_rdata, exp_data);
      check({tag, "_err"}, 32'(bus.rsp_err), 32'(err));
      check({tag, "_ready_busy"}, 32'(bus.req_ready), 32'd0);
      snap_rdata = bus.rsp_rdata;

      for (int h = 0; h < hold; h++) begin
         tick();
         check({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
         check({tag, "_hold_rdata"}, bus.rsp_rdata, snap_rdata);
         check({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
      end

      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      check({tag, "_valid_after"}, 32'(bus.rsp_valid), 32'd0);
      check({tag, "_ready_after"}, 32'(bus.req_ready), 32'd1);
      if (err) check({tag, "_addr_held"}, 32'(bus.mem_addr), 32'(addr_before));
      mem_check(tag);
      $display("txn %s we=%0d size=%0d uns=%0d addr=%0d wdata=%h rdata=%h err=%0d lat=%0d",
               tag, we, size, uns, addr, wdata, snap_rdata, err, lat);
   endtask

   initial begin
      logic [31:0] rw;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = '0;
      bus.req_wdata    = 32'h0;
      bus.rsp_ready    = 1'b0;

      rst = 1'b1;
      tick();
      tick();
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      check("rst_mem_we", 32'(bus.mem_we), 32'd0);
      check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      rst = 1'b0;
      #1;
      check("rst_release_ready", 32'(bus.req_ready), 32'd1);

      run(1'b1, 2'd2, 1'b0, 4'd4, 32'hDEADBEEF, 0, "st_w4");
      run(1'b0, 2'd2, 1'b0, 4'd4, 32'h0, 0, "ld_w4");
      run(1'b1, 2'd0, 1'b0, 4'd9, 32'h12345680, 0, "st_b9");
      run(1'b0, 2'd0, 1'b0, 4'd9, 32'h0, 0, "ld_b9_s");
      run(1'b0, 2'd0, 1'b1, 4'd9, 32'h0, 1, "ld_b9_u");
      run(1'b0, 2'd1, 1'b0, 4'd3, 32'h0, 0, "ld_h3");
      run(1'b0, 2'd2, 1'b0, 4'd12, 32'h0, 5, "ld_w12_hold");
      run(1'b0, 2'd3, 1'b0, 4'd5, 32'h0, 0, "ill_ld");
      run(1'b1, 2'd3, 1'b0, 4'd8, 32'hA5A5A5A5, 0, "ill_st");

      // Reset during the second write cycle of a word store at address 0.
      rw = 32'hC0FFEE11;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_size  = 2'd2;
      bus.req_addr  = 4'd0;
      bus.req_wdata = rw;
      tick();
      bus.req_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      check("midrst_ready_in_rst", 32'(bus.req_ready), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      ref_mem[0] = rw[7:0];
      ref_mem[1] = rw[15:8];
      check("midrst_mem_we", 32'(bus.mem_we), 32'd0);
      check("midrst_ready", 32'(bus.req_ready), 32'd1);
      check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("midrst_quiet_valid", 32'(bus.rsp_valid), 32'd0);
         check("midrst_quiet_we", 32'(bus.mem_we), 32'd0);
      end
      mem_check("midrst");
      $display("txn midrst word store addr=0 wdata=%h aborted in cycle 2", rw);

      for (int t = 0; t < 40; t++) begin
         run(1'($urandom), 2'($urandom), 1'($urandom), 4'($urandom), $urandom,
             int'($urandom_range(0, 2)), $sformatf("rnd%0d", t));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_byte_lsu.md
# mem_byte_lsu

Load/store sequencer that acts as the initiator for the core's byte-wide, 16-entry scratch memory port (synchronous write, registered-address read, 1-cycle read latency). It accepts one 32-bit byte/halfword/word load or store request at a time from the core datapath. It splits the request into little-endian byte accesses on the memory port, reassembles and extends load data, and returns a response through a valid/ready handshake.

## Interface
Parameters:
- ADDR_W, 4, byte address width of memory port (memory depth 2^ADDR_W); must be >= 2

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extend (1) / sign-extend (0); ignored for stores
- req_addr  in  ADDR_W  byte base address
- req_wdata  in  32  store data; low N bytes used
- rsp_valid  out  1  response present, held until taken
- rsp_ready  in  1  response consumer ready
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal-size request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  8  memory write byte
- mem_rdata  in  8  memory read byte, for the mem_addr of the previous cycle

## Operation
- N = 1/2/4 bytes for size 00/01/10.
- States: IDLE, WR, RD, CAP, RSP.
- IDLE: req_ready=1. On req_valid & req_ready, latch all request fields and set byte counter k=0.
  - Size 11, or req_addr not a multiple of N: go to RSP with rsp_err=1. No memory access.
  - Store: go to WR.
  - Load: go to RD.
- WR: mem_we=1, mem_addr=base+k, mem_wdata=wdata byte k (byte 0 = bits 7:0). k increments each cycle. After k=N-1, go to RSP.
- RD: mem_we=0, mem_addr=base+k. Each cycle, capture mem_rdata into byte k-1 when k>0. After issuing k=N-1, go to CAP.
- CAP: capture mem_rdata into byte N-1, then go to RSP.
- RSP: rsp_valid=1. rsp_rdata is the assembled data, zero- or sign-extended from bit 8N-1 per req_unsigned. rsp_rdata=0 for stores and errors. On rsp_ready, go to IDLE.
- Address arithmetic: base+k is computed modulo 2^ADDR_W. Aligned accesses never wrap.
- mem_we=0 in every state except WR. mem_addr/mem_wdata hold their last value outside WR/RD.
- req_* inputs are ignored outside IDLE. Request fields are latched, so changes to them mid-operation have no effect.

## Timing
- Reset values: req_ready=0 during reset, 1 in the first cycle after rst deasserts. rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_addr=0, mem_wdata=0. State IDLE, k=0.
- Reset mid-operation: abort; IDLE on the next edge. No response issued, no further writes. Bytes already written stay written.
- Accept at edge E0. Store: mem_we high in cycles 1..N. rsp_valid from cycle N+1.
- Load: addresses in cycles 1..N. rsp_valid from cycle N+2.
- Error: rsp_valid in cycle 1 after accept.
- Word load: 6 cycles accept-to-response. Byte store: 2 cycles.
- rsp_valid & rsp_ready in a cycle: req_ready=1 in the next cycle. Back-to-back throughput is one request per N+2 (store) or N+3 (load) cycles with rsp_ready tied high.
- rsp_* stay stable while rsp_valid=1 and rsp_ready=0.

## Configuration
- MEM_BYTE_LSU_MISALIGN_EN defined:
  - Misaligned halfword/word requests are executed byte-by-byte from req_addr, with the address wrapping modulo 2^ADDR_W.
  - rsp_err asserts only for size 11.
- Undefined: misaligned requests return rsp_err=1 with no memory access.

## Test plan
- Word store 0xDEADBEEF at addr 4, then word load at addr 4, signed -> mem writes EF,BE,AD,DE at addrs 4..7 in cycles 1..4; load rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid in cycle 6.
- Byte 0x80 stored at addr 9; signed byte load -> 0xFFFFFF80; unsigned byte load -> 0x00000080.
- Halfword load at addr 3 -> macro off: rsp_err=1 in cycle 1, mem_we never high, mem_addr unchanged. Macro on: reads addrs 3,4; no error.
- Word load at addr 12 with rsp_ready held low 5 cycles -> rsp_valid and data stable 5 cycles, req_ready=0 throughout, then IDLE the cycle after the handshake.
- rst pulsed during the cycle 2 of a word store at addr 0 -> only bytes 0..1 written; mem_we=0 and req_ready=1 after reset; no rsp_valid.
- req_size=11 -> rsp_err=1, rsp_rdata=0, no memory access.
